// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_cmd_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam logic WRITE_BIT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP
    } state_t;

    // Command word as it appears on the wire, MSB first.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {WRITE_BIT, addr, data};
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, shift-left transmit register; the MSB drives the serial line.
// Latency: loaded word visible on msb the cycle after load; one bit per shift.
// Backpressure: none; load has priority over shift, reset over both.
module spi_tx_shifter
    import spi_cmd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_data,
    input  logic               shift,
    output logic               msb
);

    logic [FRAME_W-1:0] sreg;

    // Zero-fill on shift so the line idles low once the frame is fully sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= load_data;
        end else if (shift) begin
            sreg <= {sreg[FRAME_W-2:0], 1'b0};
        end
    end

    assign msb = sreg[FRAME_W-1];

endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 write-command master: one 16-bit {write, addr, data} frame per accepted request.
// Latency: ncs falls the cycle after acceptance; a frame occupies 35*CLK_DIV cycles up to done.
// Backpressure: req_ready is high only in IDLE; requests while busy are ignored, never queued.
module spi_cmd_master
    import spi_cmd_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              sclk,
    output logic              copi,
    output logic              ncs,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] hcnt;
    logic [3:0]       bit_cnt;
    logic             load;
    logic             shift;

    // Capture happens only on the accepting cycle; the frame is then private to the shifter.
    assign load  = (state == IDLE) && req_valid;
    // Advancing at the end of the high phase puts the next bit on copi together with the falling sclk.
    assign shift = (state == SHIFT_HI) && (hcnt == '0);

    spi_tx_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (build_frame(req_addr, req_data)),
        .shift     (shift),
        .msb       (copi)
    );

    // Frame timing FSM; every pin level is registered on the edge that enters its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hcnt      <= HALF_RELOAD;
            bit_cnt   <= 4'd15;
            sclk      <= 1'b0;
            ncs       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= SETUP;
                        hcnt      <= HALF_RELOAD;
                        bit_cnt   <= 4'd15;
                        ncs       <= 1'b0;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                SETUP: begin
                    if (hcnt == '0) begin
                        state <= SHIFT_HI;
                        hcnt  <= HALF_RELOAD;
                        sclk  <= 1'b1;
                    end else begin
                        hcnt <= hcnt - CNT_ONE;
                    end
                end
                SHIFT_HI: begin
                    if (hcnt == '0) begin
                        state <= SHIFT_LO;
                        hcnt  <= HALF_RELOAD;
                        sclk  <= 1'b0;
                    end else begin
                        hcnt <= hcnt - CNT_ONE;
                    end
                end
                SHIFT_LO: begin
                    if (hcnt == '0) begin
                        hcnt <= HALF_RELOAD;
                        if (bit_cnt == 4'd0) begin
                            state <= HOLD;
                        end else begin
                            state   <= SHIFT_HI;
                            sclk    <= 1'b1;
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end else begin
                        hcnt <= hcnt - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (hcnt == '0) begin
                        state <= GAP;
                        hcnt  <= HALF_RELOAD;
                        ncs   <= 1'b1;
                    end else begin
                        hcnt <= hcnt - CNT_ONE;
                    end
                end
                GAP: begin
                    if (hcnt == '0) begin
                        state     <= IDLE;
                        hcnt      <= HALF_RELOAD;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        hcnt <= hcnt - CNT_ONE;
                        // Pulse lands on the final GAP cycle.
                        if (hcnt == CNT_ONE) begin
                            done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    hcnt      <= HALF_RELOAD;
                    sclk      <= 1'b0;
                    ncs       <= 1'b1;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master at CLK_DIV=4 and CLK_DIV=2 with a frame scoreboard.
// Latency: n/a.
// Backpressure: requests wait for req_ready before being driven.
module tb_spi_cmd_master;

    typedef struct {
        logic [15:0] bits;
        int          rises;
        int          low;
        bit          ph_ok;
        bit          rdy_ok;
        bit          stab_ok;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid [2];
    logic [6:0] req_addr  [2];
    logic [7:0] req_data  [2];
    logic       ready_w [2];
    logic       sclk_w  [2];
    logic       copi_w  [2];
    logic       ncs_w   [2];
    logic       busy_w  [2];
    logic       done_w  [2];

    int nchk  = 0;
    int nfail = 0;
    int cyc   = 0;

    logic [15:0] sbq0 [$];
    logic [15:0] sbq1 [$];
    frame_t      frq0 [$];
    frame_t      frq1 [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    spi_cmd_master #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(ready_w[0]),
        .req_addr(req_addr[0]), .req_data(req_data[0]), .sclk(sclk_w[0]),
        .copi(copi_w[0]), .ncs(ncs_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    spi_cmd_master #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(ready_w[1]),
        .req_addr(req_addr[1]), .req_data(req_data[1]), .sclk(sclk_w[1]),
        .copi(copi_w[1]), .ncs(ncs_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    // Peripheral stand-in: samples on sclk rise, presents the data byte when ncs rises.
    logic [15:0] prx    = '0;
    logic [7:0]  uo_out = '0;
    always @(posedge sclk_w[0]) if (ncs_w[0] === 1'b0) prx <= {prx[14:0], copi_w[0]};
    always @(posedge ncs_w[0]) uo_out <= prx[7:0];

    // Frame monitor, sampled on the falling system clock edge.
    int          cdv [2]       = '{4, 2};
    logic        prev_ncs [2]  = '{1'b1, 1'b1};
    logic        prev_sclk [2];
    logic        prev_copi [2];
    logic [15:0] cap [2];
    int          rises [2];
    int          lowcnt [2];
    int          run [2];
    int          stray [2]     = '{0, 0};
    int          done_cnt [2]  = '{0, 0};
    bit          ph_ok [2];
    bit          rdy_ok [2];
    bit          stab_ok [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ncs_w[i] === 1'b0) begin
                if (prev_ncs[i] !== 1'b0) begin
                    cap[i] = '0; rises[i] = 0; lowcnt[i] = 0; run[i] = 0;
                    ph_ok[i] = 1'b1; rdy_ok[i] = 1'b1; stab_ok[i] = 1'b1;
                end
                lowcnt[i]++;
                if (ready_w[i] !== 1'b0) rdy_ok[i] = 1'b0;
                if (sclk_w[i] !== prev_sclk[i]) begin
                    if (run[i] != cdv[i]) ph_ok[i] = 1'b0;
                    run[i] = 0;
                end
                if (sclk_w[i] === 1'b1 && prev_sclk[i] === 1'b0) begin
                    cap[i] = {cap[i][14:0], copi_w[i]};
                    rises[i]++;
                end
                if (sclk_w[i] === 1'b1 && prev_sclk[i] === 1'b1 && copi_w[i] !== prev_copi[i])
                    stab_ok[i] = 1'b0;
                run[i]++;
            end else begin
                if (sclk_w[i] === 1'b1 && prev_sclk[i] !== 1'b1) stray[i]++;
                if (prev_ncs[i] === 1'b0) begin
                    if (i == 0) frq0.push_back('{cap[i], rises[i], lowcnt[i], ph_ok[i], rdy_ok[i], stab_ok[i]});
                    else        frq1.push_back('{cap[i], rises[i], lowcnt[i], ph_ok[i], rdy_ok[i], stab_ok[i]});
                end
            end
            if (done_w[i] === 1'b1) done_cnt[i]++;
            prev_ncs[i]  = ncs_w[i];
            prev_sclk[i] = sclk_w[i];
            prev_copi[i] = copi_w[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fq_size(input int k);
        return (k == 0) ? frq0.size() : frq1.size();
    endfunction

    function automatic frame_t fq_pop(input int k);
        return (k == 0) ? frq0.pop_front() : frq1.pop_front();
    endfunction

    function automatic logic [15:0] sb_pop(input int k);
        if (k == 0) return (sbq0.size() > 0) ? sbq0.pop_front() : 16'hxxxx;
        return (sbq1.size() > 0) ? sbq1.pop_front() : 16'hxxxx;
    endfunction

    // Wait for req_ready, present one command, check the first-cycle response.
    task automatic send(input int k, input logic [6:0] a, input logic [7:0] d, input string tag);
        int n = 0;
        while (ready_w[k] !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        chk({tag, "_ready_wait"}, 32'(n < 400), 32'd1);
        req_valid[k] = 1'b1; req_addr[k] = a; req_data[k] = d;
        if (k == 0) sbq0.push_back({1'b1, a, d}); else sbq1.push_back({1'b1, a, d});
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        req_addr[k]  = 7'($urandom);
        req_data[k]  = 8'($urandom);
        chk({tag, "_ncs_fall"}, 32'(ncs_w[k]), 32'd0);
        chk({tag, "_busy"},     32'(busy_w[k]), 32'd1);
        chk({tag, "_ready_lo"}, 32'(ready_w[k]), 32'd0);
    endtask

    task automatic check_frame(input int k, input string tag);
        int n = 0;
        frame_t r;
        logic [15:0] e;
        while (fq_size(k) == 0 && n < 2000) begin @(negedge clk); n++; end
        chk({tag, "_frame_seen"}, 32'(n < 2000), 32'd1);
        if (fq_size(k) > 0) begin
            r = fq_pop(k);
            e = sb_pop(k);
            chk({tag, "_bits"},       32'(r.bits), 32'(e));
            chk({tag, "_rises"},      32'(r.rises), 32'd16);
            chk({tag, "_ncs_low"},    32'(r.low), 32'(34 * cdv[k]));
            chk({tag, "_phase_len"},  32'(r.ph_ok), 32'd1);
            chk({tag, "_ready_low"},  32'(r.rdy_ok), 32'd1);
            chk({tag, "_copi_stable"}, 32'(r.stab_ok), 32'd1);
        end
    endtask

    task automatic wait_idle(input int k, input int exp_done, input string tag);
        int n = 0;
        while (ready_w[k] !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        chk({tag, "_idle_wait"}, 32'(n < 400), 32'd1);
        chk({tag, "_done_cnt"}, 32'(done_cnt[k]), 32'(exp_done));
    endtask

    int acc [3];

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_addr[k] = '0; req_data[k] = '0;
        end

        // Reset, with a request presented during the last reset cycle.
        repeat (3) @(posedge clk);
        #1 req_valid[0] = 1'b1; req_addr[0] = 7'h11; req_data[0] = 8'h22;
        @(posedge clk); #1;
        rst = 1'b0; req_valid[0] = 1'b0;
        chk("rst_ncs",   32'(ncs_w[0]), 32'd1);
        chk("rst_sclk",  32'(sclk_w[0]), 32'd0);
        chk("rst_copi",  32'(copi_w[0]), 32'd0);
        chk("rst_busy",  32'(busy_w[0]), 32'd0);
        chk("rst_done",  32'(done_w[0]), 32'd0);
        chk("rst_ready", 32'(ready_w[0]), 32'd1);
        chk("rst_busy2", 32'(busy_w[1]), 32'd0);
        @(posedge clk); #1;
        chk("rst_prio_no_accept", 32'(busy_w[0]), 32'd0);

        // addr 0x00 data 0xFF, then addr 0x7F data 0x00.
        send(0, 7'h00, 8'hFF, "w00ff");
        check_frame(0, "w00ff");
        wait_idle(0, 1, "w00ff");
        send(0, 7'h7F, 8'h00, "w7f00");
        check_frame(0, "w7f00");
        wait_idle(0, 2, "w7f00");

        // req_valid held high across three frames.
        req_valid[0] = 1'b1; req_addr[0] = 7'h2D; req_data[0] = 8'h3C;
        for (int f = 0; f < 3; f++) begin
            n = 0;
            while (ready_w[0] !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
            chk("cont_ready_wait", 32'(n < 400), 32'd1);
            acc[f] = cyc + 1;
            sbq0.push_back({1'b1, 7'h2D, 8'h3C});
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        chk("cont_spacing_1", 32'(acc[1] - acc[0]), 32'd141);
        chk("cont_spacing_2", 32'(acc[2] - acc[1]), 32'd141);
        check_frame(0, "cont1");
        check_frame(0, "cont2");
        check_frame(0, "cont3");
        wait_idle(0, 5, "cont");

        // Reset after the 5th sclk rise aborts the frame.
        send(0, 7'h55, 8'hA5, "abort");
        @(negedge clk);
        n = 0;
        while (rises[0] < 5 && n < 400) begin @(negedge clk); n++; end
        chk("abort_rise_wait", 32'(n < 400), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ncs",  32'(ncs_w[0]), 32'd1);
        chk("abort_sclk", 32'(sclk_w[0]), 32'd0);
        chk("abort_copi", 32'(copi_w[0]), 32'd0);
        chk("abort_busy", 32'(busy_w[0]), 32'd0);
        n = 0;
        while (frq0.size() == 0 && n < 10) begin @(negedge clk); n++; end
        chk("abort_frame_end", 32'(frq0.size()), 32'd1);
        if (frq0.size() > 0) void'(frq0.pop_front());
        void'(sb_pop(0));
        repeat (12) @(posedge clk);
        #1 chk("abort_no_done", 32'(done_cnt[0]), 32'd5);
        send(0, 7'h12, 8'h34, "post_abort");
        check_frame(0, "post_abort");
        wait_idle(0, 6, "post_abort");

        // Peripheral stand-in receives 0xF0.
        send(0, 7'h00, 8'hF0, "loop");
        n = 0;
        while (ncs_w[0] !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        n = 0;
        while (uo_out !== 8'hF0 && n < 10) begin @(posedge clk); #1; n++; end
        chk("loop_uo_out", 32'(uo_out), 32'hF0);
        check_frame(0, "loop");
        wait_idle(0, 7, "loop");

        // CLK_DIV=2 instance.
        send(1, 7'h2A, 8'hC3, "div2");
        check_frame(1, "div2");
        wait_idle(1, 1, "div2");

        chk("stray_rises_div4", 32'(stray[0]), 32'd0);
        chk("stray_rises_div2", 32'(stray[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/spi_cmd_master.md
SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per SCLK half-period; legal range 2..255.
REQ-002 clk  in  1  system clock; all logic on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  command request.
REQ-005 req_ready  out  1  high only in IDLE; a command is accepted on a cycle where req_valid && req_ready.
REQ-006 req_addr  in  7  register address.
REQ-007 req_data  in  8  write data.
REQ-008 sclk  out  1  SPI clock, mode 0 (idle low).
REQ-009 copi  out  1  serial data to the peripheral, MSB first.
REQ-010 ncs  out  1  chip select, active low.
REQ-011 busy  out  1  high from acceptance until return to IDLE.
REQ-012 done  out  1  one-cycle pulse at the end of each completed frame.

Function
REQ-013 Frame SHALL be 16 bits {1'b1 (write), req_addr[6:0], req_data[7:0]}, captured into a shift register at acceptance; inputs are ignored afterwards.
REQ-014 States SHALL be IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP.
REQ-015 IDLE: ncs=1, sclk=0, copi=0, req_ready=1, busy=0; on acceptance go to SETUP next cycle.
REQ-016 SETUP: ncs=0, copi=frame bit 15, sclk=0 for CLK_DIV cycles, then SHIFT_HI.
REQ-017 SHIFT_HI: sclk=1 for CLK_DIV cycles; copi stable; then SHIFT_LO.
REQ-018 SHIFT_LO: sclk=0 for CLK_DIV cycles; copi advances to the next bit on entry (falling edge); after bit 0's low phase go to HOLD, else SHIFT_HI.
REQ-019 HOLD: ncs=0, sclk=0 for CLK_DIV cycles, then GAP.
REQ-020 GAP: ncs=1 for CLK_DIV cycles; done=1 on the last GAP cycle; IDLE next cycle.
REQ-021 ncs low duration SHALL be exactly 34*CLK_DIV cycles; exactly 16 sclk rising edges per frame, all while ncs=0.
REQ-022 Timing: ncs falls the cycle after acceptance; req_ready rises the cycle after done; minimum acceptance-to-acceptance spacing 35*CLK_DIV+1 cycles.
REQ-023 req_valid while busy SHALL be ignored; no queuing.
REQ-024 Half-period counter SHALL be ceil(log2(CLK_DIV)) bits wide, reloaded on every state entry; bit counter 4 bits, wraps only via reset to 15 at acceptance.
REQ-025 All outputs SHALL be driven from registers (no combinational path from req_* to SPI pins).

Reset
REQ-026 rst sampled high SHALL force next cycle: IDLE, ncs=1, sclk=0, copi=0, busy=0, done=0, req_ready=1.
REQ-027 rst mid-frame SHALL abort the frame without a done pulse; the partially shifted command is discarded.
REQ-028 rst has priority over acceptance in the same cycle; no command is accepted.

Structure
REQ-029 Shared package spi_cmd_pkg SHALL hold the state enum, FRAME_W=16, ADDR_W=7, DATA_W=8, WRITE_BIT=1'b1.
REQ-030 One sub-module, spi_tx_shifter (16-bit parallel-load, shift-on-enable, MSB out), is natural; timing FSM stays in spi_cmd_master.

Verification
REQ-031 CLK_DIV=4, write addr 0x00 data 0xFF -> sampled copi on sclk rises = 0x80FF, ncs low 136 cycles, one done.
REQ-032 Write addr 0x7F data 0x00 -> bitstream 0xFF00; copi changes only while sclk=0 or at setup.
REQ-033 req_valid held high continuously -> frames start 141 cycles apart; req_ready low throughout each frame.
REQ-034 rst asserted after 5th sclk rise -> next cycle ncs=1, sclk=0, busy=0; no done; next request yields a clean full frame.
REQ-035 Loopback to the team's SPI peripheral design: write addr 0x00 data 0xF0 -> peripheral uo_out == 0xF0 within 10 cycles of ncs rising.
REQ-036 CLK_DIV=2 -> ncs low 68 cycles, sclk high/low 2 cycles each, 16 rises.
